apb_wrr_arbiter: RTL and testbench
==================================

Name: apb_wrr_arbiter

Overview:
- Weighted round-robin arbiter and transfer sequencer for a shared APB slave port with N requesting masters.
- Produces a registered one-hot grant and an index that steer the APB mux datapath.
- Tracks SETUP/ACCESS phases, charges per-master credits on each completed transfer, and aborts transfers whose slave never asserts PREADY.

Parameters:
NUM_APB_MASTERS, 16, number of requesters (>=2)
WEIGHT_WIDTH, 4, width of each per-master weight/credit counter
TIMEOUT_WIDTH, 12, width of the ACCESS watchdog counter and limit

Ports:
PCLK  input  1  clock; all state updates on rising edge
PRESET  input  1  synchronous reset, active-high
req_i  input  NUM_APB_MASTERS  per-master request (PSEL of each master), packed
weight_i  input  NUM_APB_MASTERS*WEIGHT_WIDTH  per-master weight, master i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
timeout_cfg_i  input  TIMEOUT_WIDTH  ACCESS cycle limit; 0 disables the watchdog
pready_i  input  1  PREADY from the shared slave
gnt_o  output  NUM_APB_MASTERS  one-hot grant, registered
gnt_idx_o  output  $clog2(NUM_APB_MASTERS)  binary index of the granted master
gnt_valid_o  output  1  grant active (SETUP or ACCESS)
access_o  output  1  high in ACCESS (drives PENABLE gating)
timeout_o  output  1  one-cycle pulse when the watchdog aborts a transfer

Behaviour:
- Reset (PRESET=1 at clock edge): state=IDLE; gnt_o=0; gnt_idx_o=0; gnt_valid_o=0; access_o=0; timeout_o=0; ptr=0; watchdog=0. Every credit[i] loads max(weight_i[i],1).
- FSM states: IDLE, SETUP, ACCESS.
- IDLE -> SETUP when |req_i. The winner is the first requesting master found searching from ptr upward, wrapping modulo N. The gnt_o/gnt_idx_o registers load the winner on the same edge. Latency: req_i sampled high in cycle t gives gnt_o in cycle t+1.
- SETUP -> ACCESS unconditionally after 1 cycle. gnt_valid_o=1 and access_o=0 in SETUP.
- ACCESS: gnt_valid_o=1, access_o=1. The watchdog increments every cycle.
- ACCESS -> IDLE when pready_i=1 (normal completion).
- ACCESS -> IDLE when timeout_cfg_i!=0, the watchdog equals timeout_cfg_i-1, and pready_i=0 (abort). timeout_o=1 for the cycle after the abort edge.
- Grant and outputs in IDLE: gnt_o, gnt_valid_o and access_o are cleared on the edge back to IDLE. At least one IDLE cycle separates transfers, so back-to-back throughput is one transfer per 3+ cycles.
- Credit update on normal completion for granted master g:
  - If credit[g]>1: credit[g] decrements and ptr stays at g, so g keeps priority.
  - If credit[g]==1: credit[g] reloads max(weight_i[g],1) and ptr becomes (g+1) mod N.
- On abort: credit[g] reloads and ptr becomes (g+1) mod N unconditionally, so a hung transfer never keeps priority.
- If pready_i=1 and the watchdog limit land in the same cycle, completion wins and no timeout pulse is generated.
- A weight of 0 is treated as 1. A weight change takes effect at that master's next reload.
- Once granted, deassertion of req_i is ignored. The grant holds until completion or abort.
- The watchdog clears on entry to SETUP and is frozen outside ACCESS. With timeout_cfg_i=0 it may saturate, but it never wraps and never fires.
- pready_i is ignored outside ACCESS.
- Reset asserted mid-transfer returns to the reset state on the next edge with no completion or credit update.

Decomposition:
- Package apb_arb_pkg:
  - state_t enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10)
  - helper function clog2-safe index width
- Sub-module rr_first_one, combinational:
  - inputs: req vector, ptr
  - outputs: one-hot and index of the first set bit at or after ptr, wrapping
  - found flag

Test Plan:
- Reset, then req_i=16'h0001 with all weights 1 and pready_i=1 in ACCESS -> gnt_o=0x0001 one cycle after req; SETUP 1 cycle, ACCESS 1 cycle, IDLE; ptr=1.
- req_i=0x0007 held, all weights 1 -> grant order 0,1,2,0,1,2, with each grant separated by one IDLE cycle.
- weight_i[0]=3, others 1, req_i=0x0003 held -> order 0,0,0,1,0,0,0,1.
- timeout_cfg_i=4, req_i=0x0002, pready_i=0 -> 4 ACCESS cycles, then IDLE; timeout_o pulses once; ptr=2; master 1 credit reloaded.
- timeout_cfg_i=4 with pready_i=1 on the 4th ACCESS cycle -> normal completion; timeout_o stays 0.
- PRESET=1 during ACCESS of master 5 with weight 2 -> next cycle state=IDLE, gnt_o=0, ptr=0, credit[5]=2; the next req_i=0x0020 is granted normally.

Source files
------------

// File: rtl/apb_wrr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_pkg
// Description : Shared types and helpers for the APB weighted round-robin
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    // Width of a binary index over n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wrr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_wrr_arbiter_if
// Description : Request/grant bundle between the APB masters, the shared
//               slave and the weighted round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_wrr_arbiter_if #(
    parameter int NUM_APB_MASTERS = 16,
    parameter int WEIGHT_WIDTH    = 4,
    parameter int TIMEOUT_WIDTH   = 12
);
    localparam int c_IDX_W = apb_arb_pkg::idx_width(NUM_APB_MASTERS);

    logic [NUM_APB_MASTERS-1:0]              req_i;
    logic [NUM_APB_MASTERS*WEIGHT_WIDTH-1:0] weight_i;
    logic [TIMEOUT_WIDTH-1:0]                timeout_cfg_i;
    logic                                    pready_i;
    logic [NUM_APB_MASTERS-1:0]              gnt_o;
    logic [c_IDX_W-1:0]                      gnt_idx_o;
    logic                                    gnt_valid_o;
    logic                                    access_o;
    logic                                    timeout_o;

    modport master (
        output req_i, weight_i, timeout_cfg_i, pready_i,
        input  gnt_o, gnt_idx_o, gnt_valid_o, access_o, timeout_o
    );

    modport slave (
        input  req_i, weight_i, timeout_cfg_i, pready_i,
        output gnt_o, gnt_idx_o, gnt_valid_o, access_o, timeout_o
    );

endinterface
`default_nettype wire

// File: rtl/apb_wrr_arbiter_rr_first_one.sv
`default_nettype none
// ============================================================================
// Module      : rr_first_one
// Description : Finds the first set request bit at or after ptr, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_first_one #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  wire logic [WIDTH-1:0] req,
    input  wire logic [IDX_W-1:0] ptr,
    output logic      [WIDTH-1:0] onehot,
    output logic      [IDX_W-1:0] idx,
    output logic                  found
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        w_sum  = '0;
        w_pos  = '0;
        for (int k = 0; k < WIDTH; k++) begin
            // Extra sum bit keeps ptr+k from overflowing before the wrap.
            w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(WIDTH)) begin
                w_sum = w_sum - (IDX_W+1)'(WIDTH);
            end
            w_pos = w_sum[IDX_W-1:0];
            if (!found && req[w_pos]) begin
                found         = 1'b1;
                onehot[w_pos] = 1'b1;
                idx           = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_wrr_arbiter
// Description : Weighted round-robin grant and SETUP/ACCESS sequencer for a
//               shared APB slave, with per-master credits and ACCESS watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wrr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_APB_MASTERS = 16,
    parameter int WEIGHT_WIDTH    = 4,
    parameter int TIMEOUT_WIDTH   = 12
) (
    input wire logic         PCLK,
    input wire logic         PRESET,
    apb_wrr_arbiter_if.slave bus
);

    localparam int c_IDX_W = idx_width(NUM_APB_MASTERS);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [NUM_APB_MASTERS-1:0] r_gnt;
    logic [c_IDX_W-1:0]         r_gnt_idx;
    logic                       r_timeout;
    logic [c_IDX_W-1:0]         r_ptr;
    logic [TIMEOUT_WIDTH-1:0]   r_wdog;
    logic [WEIGHT_WIDTH-1:0]    r_credit [NUM_APB_MASTERS];

    logic [WEIGHT_WIDTH-1:0]    w_reload [NUM_APB_MASTERS];
    logic [NUM_APB_MASTERS-1:0] w_win_onehot;
    logic [c_IDX_W-1:0]         w_win_idx;
    logic                       w_win_found;
    logic                       w_grant;
    logic                       w_done;
    logic                       w_abort;
    logic                       w_wdog_hit;
    logic [c_IDX_W-1:0]         w_ptr_next_master;

    rr_first_one #(
        .WIDTH (NUM_APB_MASTERS),
        .IDX_W (c_IDX_W)
    ) u_rr_first_one (
        .req    (bus.req_i),
        .ptr    (r_ptr),
        .onehot (w_win_onehot),
        .idx    (w_win_idx),
        .found  (w_win_found)
    );

    // A zero weight still earns one transfer per turn.
    generate
        for (genvar i = 0; i < NUM_APB_MASTERS; i++) begin : g_reload
            assign w_reload[i] = (bus.weight_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0)
                               ? WEIGHT_WIDTH'(1)
                               : bus.weight_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    endgenerate

    assign w_wdog_hit = (bus.timeout_cfg_i != '0) &&
                        (r_wdog == (bus.timeout_cfg_i - TIMEOUT_WIDTH'(1)));

    assign w_ptr_next_master = (r_gnt_idx == c_IDX_W'(NUM_APB_MASTERS - 1))
                             ? '0 : (r_gnt_idx + c_IDX_W'(1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Completion is checked before the watchdog so a late PREADY still wins.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_win_found) begin
                    w_state_next = SETUP;
                    w_grant      = 1'b1;
                end
            end
            SETUP: begin
                w_state_next = ACCESS;
            end
            ACCESS: begin
                if (bus.pready_i) begin
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                end else if (w_wdog_hit) begin
                    w_state_next = IDLE;
                    w_abort      = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_timeout <= 1'b0;
            r_ptr     <= '0;
            r_wdog    <= '0;
            for (int i = 0; i < NUM_APB_MASTERS; i++) begin
                r_credit[i] <= w_reload[i];
            end
        end else begin
            r_timeout <= w_abort;

            if (w_grant) begin
                r_gnt     <= w_win_onehot;
                r_gnt_idx <= w_win_idx;
            end else if (w_done || w_abort) begin
                r_gnt <= '0;
            end

            if (w_grant) begin
                r_wdog <= '0;
            end else if ((r_state == ACCESS) && (r_wdog != '1)) begin
                r_wdog <= r_wdog + TIMEOUT_WIDTH'(1);
            end

            // Spare credit keeps priority; the last credit or an abort rotates.
            if (w_done && (r_credit[r_gnt_idx] > WEIGHT_WIDTH'(1))) begin
                r_credit[r_gnt_idx] <= r_credit[r_gnt_idx] - WEIGHT_WIDTH'(1);
                r_ptr               <= r_gnt_idx;
            end else if (w_done || w_abort) begin
                r_credit[r_gnt_idx] <= w_reload[r_gnt_idx];
                r_ptr               <= w_ptr_next_master;
            end
        end
    end

    assign bus.gnt_o       = r_gnt;
    assign bus.gnt_idx_o   = r_gnt_idx;
    assign bus.gnt_valid_o = (r_state != IDLE);
    assign bus.access_o    = (r_state == ACCESS);
    assign bus.timeout_o   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_wrr_arbiter
// Description : Scoreboard bench for apb_wrr_arbiter with a queue-based
//               reference model of the weighted round-robin rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_wrr_arbiter;

    localparam int N  = 16;
    localparam int WW = 4;
    localparam int TW = 12;

    typedef struct {
        int idx;
        int alen;
        bit to;
        int gap;
    } exp_t;

    logic PCLK;
    logic PRESET;

    apb_wrr_arbiter_if #(.NUM_APB_MASTERS(N), .WEIGHT_WIDTH(WW), .TIMEOUT_WIDTH(TW)) bif ();

    apb_wrr_arbiter #(
        .NUM_APB_MASTERS (N),
        .WEIGHT_WIDTH    (WW),
        .TIMEOUT_WIDTH   (TW)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bif)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    int   m_credit [N];
    int   m_ptr;
    bit   mon_in_xfer = 1'b0;

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    function automatic void check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic int wt(input int i);
        int w;
        w = int'(bif.weight_i[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_credit[i] = wt(i);
        m_ptr = 0;
    endfunction

    function automatic int model_pick(input logic [N-1:0] req);
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_update(input int g, input bit to);
        if (!to && m_credit[g] > 1) begin
            m_credit[g] = m_credit[g] - 1;
            m_ptr       = g;
        end else begin
            m_credit[g] = wt(g);
            m_ptr       = (g + 1) % N;
        end
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t cur;
        int   acc_cnt;
        int   idle_cnt;
        cur      = '{idx: 0, alen: -1, to: 1'b0, gap: -1};
        acc_cnt  = 0;
        idle_cnt = 0;
        forever begin
            @(negedge PCLK);
            if (bif.gnt_valid_o && !mon_in_xfer) begin
                mon_in_xfer = 1'b1;
                acc_cnt     = 0;
                if (sb_q.size() == 0) begin
                    check("unexpected_grant", 1, 0);
                    cur = '{idx: 0, alen: -1, to: 1'b0, gap: -1};
                end else begin
                    cur = sb_q.pop_front();
                    check("gnt_idx", bif.gnt_idx_o, cur.idx);
                    check("gnt_onehot", bif.gnt_o, longint'(1) << cur.idx);
                    check("setup_access_low", bif.access_o, 0);
                    check("timeout_quiet", bif.timeout_o, 0);
                    if (cur.gap >= 0) check("idle_gap", idle_cnt, cur.gap);
                end
            end else if (bif.gnt_valid_o) begin
                if (bif.access_o) acc_cnt++;
            end else if (mon_in_xfer) begin
                mon_in_xfer = 1'b0;
                idle_cnt    = 1;
                check("gnt_cleared", bif.gnt_o, 0);
                if (cur.alen >= 0) begin
                    check("access_cycles", acc_cnt, cur.alen);
                    check("timeout_pulse", bif.timeout_o, cur.to);
                end
            end else begin
                idle_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic set_weights(input int w_all, input int who, input int w_who);
        for (int i = 0; i < N; i++) begin
            bif.weight_i[i*WW +: WW] = WW'((i == who) ? w_who : w_all);
        end
    endtask

    task automatic wait_access(input bit rand_pready);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bif.access_o) begin
                ok = 1'b1;
                break;
            end
            bif.pready_i = rand_pready ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge PCLK);
        end
        if (!ok) begin
            check("access_reached", 0, 1);
            finish_test();
        end
    endtask

    // plen_mode: -1 random, 0 never ready, k>0 ready on the k-th ACCESS cycle
    task automatic run_batch(input logic [N-1:0] req, input int n, input int plen_mode);
        for (int t = 0; t < n; t++) begin
            int   g;
            int   plen;
            int   alen;
            int   cfg;
            bit   to;
            exp_t e;
            cfg = int'(bif.timeout_cfg_i);
            g   = model_pick(req);
            if (plen_mode < 0) begin
                plen = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
            end else begin
                plen = plen_mode;
            end
            if (plen == 0 && cfg == 0) plen = 1;
            if (cfg != 0 && (plen == 0 || plen > cfg)) begin
                to   = 1'b1;
                alen = cfg;
            end else begin
                to   = 1'b0;
                alen = plen;
            end
            e = '{idx: g, alen: alen, to: to, gap: (t == 0) ? -1 : 1};
            sb_q.push_back(e);
            if (t == 0) bif.req_i = req;
            wait_access(plen_mode < 0);
            for (int c = 1; c <= alen; c++) begin
                bif.pready_i = (!to && c == plen);
                @(negedge PCLK);
            end
            bif.pready_i = 1'b0;
            model_update(g, to);
            if (t == n - 1) bif.req_i = '0;
        end
        repeat (2) @(negedge PCLK);
    endtask

    initial begin
        logic [N-1:0] rq;
        exp_t         e;
        PRESET            = 1'b1;
        bif.req_i         = '0;
        bif.pready_i      = 1'b0;
        bif.timeout_cfg_i = '0;
        set_weights(1, 0, 1);
        repeat (3) @(negedge PCLK);
        model_reset();
        check("rst_gnt", bif.gnt_o, 0);
        check("rst_gnt_idx", bif.gnt_idx_o, 0);
        check("rst_valid", bif.gnt_valid_o, 0);
        check("rst_access", bif.access_o, 0);
        check("rst_timeout", bif.timeout_o, 0);
        PRESET = 1'b0;
        @(negedge PCLK);

        run_batch(16'h0001, 1, 1);
        run_batch(16'h0007, 6, 1);

        set_weights(1, 0, 3);
        run_batch(16'h0003, 8, 1);

        set_weights(1, 0, 1);
        bif.timeout_cfg_i = TW'(4);
        run_batch(16'h0002, 1, 0);
        run_batch(16'h0006, 1, 1);
        run_batch(16'h0002, 1, 4);
        bif.timeout_cfg_i = '0;

        // Reset in the middle of master 5's transfer.
        set_weights(1, 5, 2);
        run_batch(16'h0020, 2, 1);
        e = '{idx: model_pick(16'h0020), alen: -1, to: 1'b0, gap: -1};
        sb_q.push_back(e);
        bif.req_i = 16'h0020;
        wait_access(1'b0);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("midrst_gnt", bif.gnt_o, 0);
        check("midrst_valid", bif.gnt_valid_o, 0);
        check("midrst_access", bif.access_o, 0);
        check("midrst_timeout", bif.timeout_o, 0);
        PRESET    = 1'b0;
        bif.req_i = '0;
        model_reset();
        @(negedge PCLK);
        run_batch(16'h0021, 4, 1);
        run_batch(16'h0020, 1, 2);

        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < N; i++) bif.weight_i[i*WW +: WW] = WW'($urandom_range(0, 3));
            bif.timeout_cfg_i = TW'($urandom_range(0, 5));
            rq = N'($urandom) & N'($urandom);
            if (rq == '0) rq = N'(1) << $urandom_range(0, N - 1);
            run_batch(rq, 6, -1);
        end

        repeat (4) @(negedge PCLK);
        check("sb_drained", sb_q.size(), 0);
        check("final_idle", bif.gnt_valid_o, 0);
        finish_test();
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
